// File: rtl/button_step_conditioner.sv
`default_nettype none
// button_step_conditioner: synchronise and debounce two buttons into one-cycle inc/dec steps (rev 1.0)
// Option macro BUTTON_AUTO_REPEAT_EN: extra pulses while a button stays held.
module button_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic inc,
  output logic dec,
  output logic inc_level,
  output logic dec_level
);

  localparam int CNT_MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_PERIOD) ? CNT_MAX_A : REPEAT_PERIOD;
  localparam int CNT_W     = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_FIRST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_NEXT  = CNT_W'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} state_t;

  logic [1:0] raw;
  logic [1:0] s1_q, s2_q;
  logic [1:0] press_ev;
  logic [1:0] level;
  logic [1:0] pulse_d, pulse_q;

  assign raw = {btn_dec_raw, btn_inc_raw};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 2'b00;
      s2_q <= 2'b00;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // Index 0 is the increment button, index 1 the decrement button.
  for (genvar i = 0; i < 2; i++) begin : g_btn
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             ev_d;
`ifdef BUTTON_AUTO_REPEAT_EN
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             first_q, first_d;
`endif

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      ev_d    = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_d   = rep_q;
      first_d = first_q;
`endif
      case (state_q)
        IDLE: begin
          if (s2_q[i]) begin
            state_d = DB_PRESS;
            cnt_d   = '0;
          end
        end
        DB_PRESS: begin
          if (!s2_q[i]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = PRESSED;
            level_d = 1'b1;
            ev_d    = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
            rep_d   = '0;
            first_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!s2_q[i]) begin
            state_d = DB_RELEASE;
            cnt_d   = '0;
`ifdef BUTTON_AUTO_REPEAT_EN
            rep_d   = '0;
            first_d = 1'b1;
          end else if (rep_q == (first_q ? REP_FIRST : REP_NEXT)) begin
            ev_d    = 1'b1;
            rep_d   = '0;
            first_d = 1'b0;
          end else begin
            rep_d = rep_q + 1'b1;
`endif
          end
        end
        DB_RELEASE: begin
          if (s2_q[i]) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = IDLE;
            level_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
        rep_q   <= '0;
        first_q <= 1'b1;
`endif
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
`ifdef BUTTON_AUTO_REPEAT_EN
        rep_q   <= rep_d;
        first_q <= first_d;
`endif
      end
    end

    assign press_ev[i] = ev_d;
    assign level[i]    = level_q;
  end

  // Simultaneous events cancel each other so inc and dec are never high together.
  always_comb begin
    pulse_d = press_ev;
    if (&press_ev) pulse_d = 2'b00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pulse_q <= 2'b00;
    else      pulse_q <= pulse_d;
  end

  assign inc       = pulse_q[0];
  assign dec       = pulse_q[1];
  assign inc_level = level[0];
  assign dec_level = level[1];

endmodule
`default_nettype wire

// File: tb/tb_button_step_conditioner.sv
`default_nettype none
// tb_button_step_conditioner: scoreboard bench, expected pulse cycles queued at stimulus time.
module tb_button_step_conditioner;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst, btn_inc_raw, btn_dec_raw;
  logic inc, dec, inc_level, dec_level;

  button_step_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_inc_raw(btn_inc_raw),
    .btn_dec_raw(btn_dec_raw),
    .inc        (inc),
    .dec        (dec),
    .inc_level  (inc_level),
    .dec_level  (dec_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        is_dec;
    logic [31:0] at;
  } pulse_t;
  pulse_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic is_dec, input int at);
    pulse_t p;
    p.is_dec = is_dec;
    p.at     = at;
    exp_q.push_back(p);
  endtask

  task automatic end_test(input string tag);
    check({tag, "_missing_pulses"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin : monitor
    pulse_t p;
    if (inc || dec) begin
      if (inc && dec) begin
        check("inc_and_dec_together", 1, 0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        p = exp_q.pop_front();
        check("pulse_cycle", cyc, p.at);
        check("pulse_kind", dec, p.is_dec);
      end
    end
  end

  int n, m, b, r;
  logic [9:0] pat;

  initial begin
    rst = 1'b0;
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;
    tick(3);
    check("reset_outputs", {inc, dec, inc_level, dec_level}, 0);
    rst = 1'b1;
    tick(3);

    // Single held press on inc.
    n = cyc;
    expect_pulse(1'b0, n + 3 + DB);
`ifdef BUTTON_AUTO_REPEAT_EN
    expect_pulse(1'b0, n + 23 + DB);
    expect_pulse(1'b0, n + 33 + DB);
    expect_pulse(1'b0, n + 43 + DB);
`endif
    btn_inc_raw = 1'b1;
    tick(2 + DB);
    check("t1_level_early", inc_level, 0);
    tick(1);
    check("t1_level_set", inc_level, 1);
    check("t1_dec_level", dec_level, 0);
    tick(50 - 3 - DB);
    m = cyc;
    btn_inc_raw = 1'b0;
    tick(DB + 2);
    check("t1_level_hold", inc_level, 1);
    tick(1);
    check("t1_level_clear", inc_level, 0);
    tick(5);
    end_test("t1");

    // Dec chatter: 3 high / 1 low never qualifies.
    for (int i = 0; i < 10; i++) begin
      btn_dec_raw = 1'b1;
      tick(3);
      btn_dec_raw = 1'b0;
      check("t2_dec_level", dec_level, 0);
      tick(1);
    end
    tick(8);
    check("t2_dec_level_end", dec_level, 0);
    end_test("t2");

    // Press inc, then bouncy release.
    n = cyc;
    expect_pulse(1'b0, n + 3 + DB);
    btn_inc_raw = 1'b1;
    tick(15);
    b = cyc;
    pat = 10'b0011001100;
    for (int i = 0; i < 10; i++) begin
      btn_inc_raw = pat[i];
      tick(1);
    end
    btn_inc_raw = 1'b0;
    check("t3_level_bounce", inc_level, 1);
    tick(4);
    check("t3_level_hold", inc_level, 1);
    tick(1);
    check("t3_level_clear", inc_level, 0);
    tick(5);
    end_test("t3");

    // Both buttons on the same cycle.
    btn_inc_raw = 1'b1;
    btn_dec_raw = 1'b1;
    tick(2 + DB);
    check("t4_levels_early", {inc_level, dec_level}, 2'b00);
    tick(1);
    check("t4_levels_set", {inc_level, dec_level}, 2'b11);
    tick(5);
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;
    tick(12);
    check("t4_levels_clear", {inc_level, dec_level}, 2'b00);
    end_test("t4");

    // Reset during DB_PRESS and during PRESSED with inc held.
    btn_inc_raw = 1'b1;
    tick(4);
    rst = 1'b0;
    #1;
    check("t5_rst_db_press", {inc, dec, inc_level, dec_level}, 0);
    tick(2);
    r = cyc;
    rst = 1'b1;
    expect_pulse(1'b0, r + 3 + DB);
    tick(10);
    check("t5_level_after_rst", inc_level, 1);
    rst = 1'b0;
    #1;
    check("t5_rst_pressed", {inc, dec, inc_level, dec_level}, 0);
    tick(2);
    r = cyc;
    rst = 1'b1;
    expect_pulse(1'b0, r + 3 + DB);
    tick(12);
    check("t5_level_second", inc_level, 1);
    btn_inc_raw = 1'b0;
    tick(10);
    end_test("t5");

`ifdef BUTTON_AUTO_REPEAT_EN
    // Hold-to-repeat: press, +20, then every 10 cycles until release.
    n = cyc;
    expect_pulse(1'b0, n + 3 + DB);
    expect_pulse(1'b0, n + 23 + DB);
    expect_pulse(1'b0, n + 33 + DB);
    expect_pulse(1'b0, n + 43 + DB);
    expect_pulse(1'b0, n + 53 + DB);
    btn_inc_raw = 1'b1;
    tick(62);
    btn_inc_raw = 1'b0;
    tick(20);
    end_test("t6");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_step_conditioner.md
Name: button_step_conditioner

Overview:
- Upstream stage of the PWM duty-cycle block. Takes two raw mechanical push-buttons (increment and decrement), synchronises and debounces each one, and emits the single-cycle inc / dec step pulses that the PWM block consumes.
- The PWM block steps duty by 100 counts per cycle that inc is high, so a held or bouncing button must never produce more than one pulse per qualified press, unless auto-repeat is compiled in.
- Also exports the debounced button levels for status LEDs.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronised samples needed to accept a press or release; legal minimum 2.
- REPEAT_DELAY, 25000000, hold time in cycles before the first auto-repeat pulse (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (AUTO_REPEAT_EN only).
- CNT_W, $clog2(max of the three above)+1, width of the per-button counters; derived, not overridden.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- btn_inc_raw  input  1  raw increment button, asynchronous, active-high
- btn_dec_raw  input  1  raw decrement button, asynchronous, active-high
- inc  output  1  one-cycle increment step pulse, drives PWM inc
- dec  output  1  one-cycle decrement step pulse, drives PWM dec
- inc_level  output  1  debounced increment button state
- dec_level  output  1  debounced decrement button state

Behaviour:
- Reset (rst=0, asynchronous assert):
  - All outputs = 0.
  - Synchroniser flops = 0, counters = 0, both FSMs = IDLE.
  - Deassertion is taken synchronously on the next clk edge.
- Reset mid-press: FSM returns to IDLE and outputs drop immediately. A button still held after reset releases is treated as a new press and yields one pulse after full debounce.
- Synchroniser: each raw input passes through a 2-flop synchroniser; s2 is the synchronised sample.
- Per-button FSM (identical and independent for inc and dec), states IDLE, DB_PRESS, PRESSED, DB_RELEASE:
  - IDLE: s2=1 -> DB_PRESS, cnt<=0.
  - DB_PRESS:
    - s2=0 -> IDLE, cnt<=0.
    - s2=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, level<=1, press event.
    - Otherwise cnt<=cnt+1.
  - PRESSED: s2=0 -> DB_RELEASE, cnt<=0.
  - DB_RELEASE:
    - s2=1 -> PRESSED, cnt<=0 (bounce ignored).
    - s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, level<=0.
    - Otherwise cnt<=cnt+1.
- Latency: raw rises, first sampled at edge 0 -> inc/dec is 1 for exactly the cycle following edge 2+DEBOUNCE_CYCLES. Pulses and levels are registered.
- Glitch rejection: any raw pulse or gap shorter than DEBOUNCE_CYCLES samples produces no pulse and no level change.
- Press events fire only on the DB_PRESS->PRESSED transition. Release never pulses.
- Mutual exclusion:
  - If inc and dec press events occur on the same edge, both pulses are suppressed.
  - Both FSMs still advance, and both levels still go to 1.
  - A press event on one button while the other is PRESSED is emitted normally; PWM rejects inc&&dec itself, and this block never drives both high.
- Counters saturate; they never wrap while the FSM is in a non-counting state.

Optional Feature:
- Macro BUTTON_AUTO_REPEAT_EN.
- Defined:
  - In PRESSED, a per-button repeat counter runs.
  - First extra pulse fires REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles while the FSM stays PRESSED.
  - Entering DB_RELEASE or reset clears the repeat counter.
  - Repeat pulses obey the same mutual-exclusion rule.
- Undefined: exactly one pulse per qualified press; repeat counters and the REPEAT_* parameters are unused and produce no logic.

Test Plan:
- DEBOUNCE_CYCLES=4; reset, then btn_inc_raw=1 held 50 cycles -> inc=1 for exactly the one cycle after edge 6, inc_level=1 from the same cycle, dec stays 0.
- DEBOUNCE_CYCLES=4; btn_dec_raw toggles high 3 cycles / low 1 cycle repeatedly for 40 cycles -> dec and dec_level remain 0 throughout.
- DEBOUNCE_CYCLES=4; press inc, then release with 2-cycle bounce glitches for 10 cycles -> exactly one inc pulse; inc_level returns to 0 only after 4 stable low samples.
- DEBOUNCE_CYCLES=4; both raw inputs rise on the same cycle -> inc=dec=0 always, inc_level=dec_level=1 after edge 6.
- Hold btn_inc_raw, pull rst=0 mid-DB_PRESS and again in PRESSED -> outputs 0 asynchronously; after release with button still held, one inc pulse 6 edges later.
- BUTTON_AUTO_REPEAT_EN, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=10, inc held 60 cycles after press -> pulses at press+0, +20, +30, +40, +50 and none after release.
